srl16_fifo: RTL and testbench
=============================

Name: srl16_fifo

Overview:
- Synchronous FIFO whose storage is WIDTH parallel 16-deep addressable shift registers, one per data bit.
- Each storage bit behaves as an SRLC16E: shift on CE, read at address A[3:0], no reset of contents.
- The block is the control stage wrapped around those shift registers: it generates the shift enable and read address, and consumes the addressed output.
- Used as a small, LUT-cheap elastic buffer between streaming stages.

Parameters:
- WIDTH, 8, data width in bits; one shift-register column per bit.
- AF_LEVEL, 12, ALMOST_FULL asserts when LEVEL >= AF_LEVEL; legal range 1..16.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- WR_EN  input  1  write request.
- DIN  input  WIDTH  write data.
- FULL  output  1  FIFO cannot accept a write.
- ALMOST_FULL  output  1  LEVEL >= AF_LEVEL.
- RD_EN  input  1  read request / acknowledge of DOUT.
- DOUT  output  WIDTH  head-of-FIFO data, first-word fall-through; valid when EMPTY=0.
- EMPTY  output  1  no data available at DOUT.
- LEVEL  output  5  number of words held, 0..16 (0..17 with the optional feature).

Behaviour:
- Interface decided: one clock CLK; reset RST_N is asynchronous and active-low.
- Storage:
  - Shift enable = wr_acc = WR_EN & ~FULL.
  - On shift, every column shifts up one position and DIN enters position 0.
  - Storage is never reset.
- Internal counter cnt (0..16):
  - Read address = cnt-1 (4 bits), i.e. the oldest word.
  - Address is don't-care when cnt=0.
- Accepted read: rd_acc = RD_EN & ~EMPTY.
- Counter update per edge:
  - wr_acc only: cnt+1.
  - rd_acc only: cnt-1.
  - Both: cnt unchanged, so the address is unchanged. The shift moves the next-oldest word into the old address.
  - Neither: hold.
- Requests while blocked:
  - WR_EN while FULL is ignored; no shift, no error flag.
  - RD_EN while EMPTY is ignored.
  - Simultaneous write and read when FULL: the write is dropped and the read completes (FULL is evaluated before the read).
  - Simultaneous write and read when EMPTY: the write is accepted and the read is ignored.
- Flags are registered or derived from registered cnt, with no combinational path from WR_EN/RD_EN:
  - EMPTY = (cnt==0).
  - FULL = (cnt==16).
  - LEVEL = cnt.
  - ALMOST_FULL = (LEVEL >= AF_LEVEL).
- DOUT is combinational from the storage at address cnt-1. It is valid in the cycle EMPTY=0, i.e. one edge after the first accepted write.
- Reset (any time, including mid-transfer):
  - cnt=0, EMPTY=1, FULL=0, ALMOST_FULL=0, LEVEL=0, asynchronously.
  - Stored words are discarded logically.
  - DOUT content after reset is unspecified.
  - First edge after RST_N deasserts behaves as a normal edge.

Optional Feature:
- Macro: SRL16_FIFO_OREG_EN.
- Defined: a WIDTH-bit output register plus valid bit oreg_v is added after the shift-register read port.
  - DOUT is driven from the register only.
  - EMPTY = ~oreg_v.
  - Register loads storage[cnt-1] and decrements cnt when cnt>0 and (oreg_v=0 or rd_acc). This load counts as the storage read for the simultaneous-event rules.
  - oreg_v clears on rd_acc with cnt=0.
  - LEVEL = cnt + oreg_v, maximum 17.
  - FULL remains (cnt==16).
  - First-word latency is 2 edges from write to EMPTY=0.
  - Reset clears oreg_v; the register data is not reset.
- Undefined: behaviour as described in Behaviour, depth 16, 1-edge latency.

Test Plan:
- Reset, then write 0x11,0x22,0x33 on consecutive cycles, no reads -> after the 1st edge EMPTY=0 and DOUT=0x11; after the 3rd edge LEVEL=3 and DOUT still 0x11.
- Fill with 16 writes 0x00..0x0F, then assert WR_EN with DIN=0xAA -> FULL=1 from the 16th edge; LEVEL stays 16; 0xAA is never read back; sixteen reads return 0x00..0x0F in order, then EMPTY=1.
- With LEVEL=5, hold WR_EN and RD_EN together for 20 cycles with an incrementing DIN -> LEVEL constant 5; output order strictly FIFO with no loss or duplicate.
- EMPTY with WR_EN=RD_EN=1, DIN=0x5C -> write accepted, read ignored; LEVEL=1 and DOUT=0x5C next cycle. FULL with both asserted -> LEVEL=15 and the head advances.
- AF_LEVEL=12: write 11 words -> ALMOST_FULL=0; 12th write -> ALMOST_FULL=1; one read -> 0.
- Drop RST_N asynchronously mid-cycle with LEVEL=9 -> EMPTY=1, FULL=0, LEVEL=0 without waiting for CLK. With SRL16_FIFO_OREG_EN, write 0x77 into an empty FIFO -> EMPTY=0 after exactly 2 edges; fill to LEVEL=17 with FULL=1.

Source files
------------

// File: rtl/srl16_fifo.sv
// -----------------------------------------------------------------------------
// srl16_fifo
//   Small synchronous FIFO built on WIDTH parallel 16-deep addressable shift
//   registers (one SRLC16E-style column per data bit). This module is the
//   control stage around those columns. It produces the shift enable and the
//   read address, and it presents the addressed word at the output.
//   New words always enter position 0. The oldest word sits at position cnt-1.
//
//   Default build: first-word fall-through, depth 16, and 1-edge latency from
//   write to EMPTY=0. DOUT is read combinationally from the shift registers.
//
//   Optional build macro SRL16_FIFO_OREG_EN adds a registered output stage
//   with its own valid bit. This gives depth 17 and 2-edge first-word latency.
//
// Parameters
//   WIDTH     data width in bits
//   AF_LEVEL  ALMOST_FULL asserts when LEVEL >= AF_LEVEL (1..16)
//
// Ports
//   CLK          clock, rising edge
//   RST_N        asynchronous active-low reset
//   WR_EN, DIN   write request and data
//   FULL         write would be dropped
//   ALMOST_FULL  LEVEL >= AF_LEVEL
//   RD_EN        read request / acknowledge of DOUT
//   DOUT         head-of-FIFO data, valid while EMPTY=0
//   EMPTY        no data at DOUT
//   LEVEL        words held
// -----------------------------------------------------------------------------
module srl16_fifo #(
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = 12
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             WR_EN,
  input  logic [WIDTH-1:0] DIN,
  output logic             FULL,
  output logic             ALMOST_FULL,
  input  logic             RD_EN,
  output logic [WIDTH-1:0] DOUT,
  output logic             EMPTY,
  output logic [4:0]       LEVEL
);

  logic [WIDTH-1:0] srl [16];   // srl[0] is the newest word
  logic [4:0]       cnt;        // words held in the shift registers, 0..16
  logic [4:0]       cnt_next;
  logic [3:0]       rd_addr;
  logic [WIDTH-1:0] srl_q;
  logic             wr_acc;
  logic             rd_acc;
  logic             srl_pop;    // a word leaves the shift registers this edge

  assign FULL    = (cnt == 5'd16);
  assign wr_acc  = WR_EN & ~FULL;
  assign rd_acc  = RD_EN & ~EMPTY;
  // When cnt is 0 the address wraps to 15. That is harmless because the word
  // read there is never used.
  assign rd_addr = 4'(cnt - 5'd1);
  assign srl_q   = srl[rd_addr];

  // NOTE: the storage has no reset. A reset only clears the counter, so any
  // stale words become unreachable. Keeping the reset off the storage lets it
  // map onto reset-less shift-register primitives.
  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      srl[0] <= DIN;
      for (int i = 1; i < 16; i++) begin
        srl[i] <= srl[i-1];
      end
    end
  end

`ifdef SRL16_FIFO_OREG_EN
  logic [WIDTH-1:0] oreg;
  logic             oreg_v;

  // The output register pulls the oldest stored word whenever it is empty or
  // is being drained. This pull is the storage read for the counter.
  assign srl_pop = (cnt != 5'd0) && (!oreg_v || rd_acc);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      oreg_v <= 1'b0;
    end else if (srl_pop) begin
      oreg_v <= 1'b1;
    end else if (rd_acc) begin
      oreg_v <= 1'b0;
    end
  end

  // The data half of the output register is not reset. Its validity is
  // carried by oreg_v alone.
  always_ff @(posedge CLK) begin
    if (srl_pop) begin
      oreg <= srl_q;
    end
  end

  assign DOUT  = oreg;
  assign EMPTY = ~oreg_v;
  assign LEVEL = cnt + {4'd0, oreg_v};
`else
  assign srl_pop = rd_acc;
  assign DOUT    = srl_q;
  assign EMPTY   = (cnt == 5'd0);
  assign LEVEL   = cnt;
`endif

  assign ALMOST_FULL = (LEVEL >= 5'(AF_LEVEL));

  // A push and a pop on the same edge leave the address unchanged. The shift
  // moves the next-oldest word into that slot.
  // NOTE: default the output first so that every path assigns it and no latch
  // is inferred.
  always_comb begin
    cnt_next = cnt;
    if (wr_acc && !srl_pop) begin
      cnt_next = cnt + 5'd1;
    end else if (!wr_acc && srl_pop) begin
      cnt_next = cnt - 5'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the values from before the edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= 5'd0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_srl16_fifo.sv
// -----------------------------------------------------------------------------
// tb_srl16_fifo
//   Directed self-checking bench for srl16_fifo in its default build
//   (fall-through, depth 16). Inputs change and outputs are sampled 1 time
//   unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_srl16_fifo;

  localparam int WIDTH = 8;

  logic             CLK;
  logic             RST_N;
  logic             WR_EN;
  logic [WIDTH-1:0] DIN;
  logic             FULL;
  logic             ALMOST_FULL;
  logic             RD_EN;
  logic [WIDTH-1:0] DOUT;
  logic             EMPTY;
  logic [4:0]       LEVEL;

  int n_checks = 0;
  int n_pass   = 0;

  srl16_fifo #(.WIDTH(WIDTH), .AF_LEVEL(12)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .WR_EN      (WR_EN),
    .DIN        (DIN),
    .FULL       (FULL),
    .ALMOST_FULL(ALMOST_FULL),
    .RD_EN      (RD_EN),
    .DOUT       (DOUT),
    .EMPTY      (EMPTY),
    .LEVEL      (LEVEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    WR_EN = 1'b1;
    DIN   = d;
    tick();
    WR_EN = 1'b0;
  endtask

  // Check the head word, then acknowledge it.
  task automatic read_expect(input string tag, input logic [7:0] exp);
    check(tag, {24'd0, DOUT}, {24'd0, exp});
    RD_EN = 1'b1;
    tick();
    RD_EN = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0;
    WR_EN = 1'b0;
    RD_EN = 1'b0;
    DIN   = '0;
    #12;
    check("rst_empty", {31'd0, EMPTY}, 32'd1);
    check("rst_full",  {31'd0, FULL}, 32'd0);
    check("rst_af",    {31'd0, ALMOST_FULL}, 32'd0);
    check("rst_level", {27'd0, LEVEL}, 32'd0);
    RST_N = 1'b1;
    tick();

    // Three back-to-back writes. The head is visible one edge after the first.
    WR_EN = 1'b1;
    DIN   = 8'h11;
    tick();
    check("t1_empty", {31'd0, EMPTY}, 32'd0);
    check("t1_dout1", {24'd0, DOUT}, 32'h11);
    DIN = 8'h22;
    tick();
    DIN = 8'h33;
    tick();
    WR_EN = 1'b0;
    check("t1_level", {27'd0, LEVEL}, 32'd3);
    check("t1_dout3", {24'd0, DOUT}, 32'h11);
    read_expect("t1_rd", 8'h11);
    read_expect("t1_rd", 8'h22);
    read_expect("t1_rd", 8'h33);
    check("t1_drained", {31'd0, EMPTY}, 32'd1);

    // Fill to 16 and check ALMOST_FULL at the threshold. A write while full
    // is dropped.
    for (int i = 0; i < 16; i++) begin
      write_word(8'(i));
      if (i == 10) check("af_at11", {31'd0, ALMOST_FULL}, 32'd0);
      if (i == 11) check("af_at12", {31'd0, ALMOST_FULL}, 32'd1);
      if (i == 14) check("full_at15", {31'd0, FULL}, 32'd0);
    end
    check("full_at16", {31'd0, FULL}, 32'd1);
    check("level16",   {27'd0, LEVEL}, 32'd16);
    write_word(8'hAA);
    check("full_hold",  {31'd0, FULL}, 32'd1);
    check("level_hold", {27'd0, LEVEL}, 32'd16);
    for (int i = 0; i < 16; i++) begin
      read_expect("fill_rd", 8'(i));
      if (i == 3) check("af_12_left", {31'd0, ALMOST_FULL}, 32'd1);
      if (i == 4) check("af_11_left", {31'd0, ALMOST_FULL}, 32'd0);
    end
    check("fill_empty", {31'd0, EMPTY}, 32'd1);
    check("fill_level", {27'd0, LEVEL}, 32'd0);

    // Level 5, then simultaneous read and write for 20 cycles.
    for (int i = 0; i < 5; i++) write_word(8'(8'h40 + i));
    WR_EN = 1'b1;
    RD_EN = 1'b1;
    for (int k = 0; k < 20; k++) begin
      DIN = 8'(8'h45 + k);
      check("rw_head", {24'd0, DOUT}, {24'd0, 8'(8'h40 + k)});
      tick();
      check("rw_level", {27'd0, LEVEL}, 32'd5);
    end
    WR_EN = 1'b0;
    RD_EN = 1'b0;
    for (int i = 0; i < 5; i++) read_expect("rw_tail", 8'(8'h54 + i));
    check("rw_empty", {31'd0, EMPTY}, 32'd1);

    // Simultaneous read and write while empty: the write wins and the read
    // is ignored.
    WR_EN = 1'b1;
    RD_EN = 1'b1;
    DIN   = 8'h5C;
    tick();
    WR_EN = 1'b0;
    RD_EN = 1'b0;
    check("e_rw_level", {27'd0, LEVEL}, 32'd1);
    check("e_rw_empty", {31'd0, EMPTY}, 32'd0);
    read_expect("e_rw_dout", 8'h5C);

    // Simultaneous read and write while full: the write is dropped and the
    // read completes.
    for (int i = 0; i < 16; i++) write_word(8'(8'h80 + i));
    WR_EN = 1'b1;
    RD_EN = 1'b1;
    DIN   = 8'hAA;
    check("f_rw_head0", {24'd0, DOUT}, 32'h80);
    tick();
    WR_EN = 1'b0;
    RD_EN = 1'b0;
    check("f_rw_level", {27'd0, LEVEL}, 32'd15);
    check("f_rw_full",  {31'd0, FULL}, 32'd0);
    for (int i = 1; i < 16; i++) read_expect("f_rw_rd", 8'(8'h80 + i));
    check("f_rw_empty", {31'd0, EMPTY}, 32'd1);

    // Asynchronous reset mid-cycle with nine words held.
    for (int i = 0; i < 9; i++) write_word(8'(8'hC0 + i));
    check("pre_rst_level", {27'd0, LEVEL}, 32'd9);
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_empty", {31'd0, EMPTY}, 32'd1);
    check("arst_full",  {31'd0, FULL}, 32'd0);
    check("arst_level", {27'd0, LEVEL}, 32'd0);
    check("arst_af",    {31'd0, ALMOST_FULL}, 32'd0);
    #6;
    RST_N = 1'b1;
    tick();
    write_word(8'h99);
    check("post_rst_level", {27'd0, LEVEL}, 32'd1);
    read_expect("post_rst_dout", 8'h99);
    check("post_rst_empty", {31'd0, EMPTY}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
